// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop RxD synchronizer, 16x-oversampled start/data/stop FSM, LSB-first.
// Latency: RxD->rxs 2 Clk; RxDone/RxData/RxFrameErr update the Clk after the stop-bit sample tick.
// Backpressure: none; RxData is held until the next RxDone and the consumer must take each word on the pulse.
module uart_rx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Tick,
    input  logic                 RxEn,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxDone,
    output logic                 RxFrameErr,
    output logic                 RxBusy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rxs_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        ferr_d    = ferr_q;
        done_d    = 1'b0;
        if (Tick) begin
            case (state_q)
                S_IDLE: begin
                    if (RxEn && !rxs_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        // A start bit that is high again at mid-bit was only a glitch
                        state_d   = rxs_q ? S_IDLE : S_DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + BW'(1);
                        cnt_d     = '0;
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d = shift_q;
                        ferr_d    = ~rxs_q;
                        done_d    = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= RxD;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign RxData     = rx_data_q;
    assign RxDone     = done_q;
    assign RxFrameErr = ferr_q;
    assign RxBusy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: Tick every 4 Clk, 64-Clk bit period, queue scoreboard on RxDone.
module tb_uart_rx_engine;
    localparam int BIT_CLK = 64;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Tick = 1'b0;
    logic       RxEn = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] RxData;
    logic       RxDone;
    logic       RxFrameErr;
    logic       RxBusy;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;
    logic done_prev = 1'b0;
    logic [1:0] tdiv = 2'd0;

    uart_rx_engine #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .RxEn(RxEn), .RxD(RxD),
        .RxData(RxData), .RxDone(RxDone), .RxFrameErr(RxFrameErr), .RxBusy(RxBusy)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        tdiv = tdiv + 2'd1;
        Tick = (tdiv == 2'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every RxDone must match the oldest pending frame
    always @(negedge Clk) begin
        cyc++;
        if (RxDone) begin
            exp_t e;
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            chk("done_width", done_prev, 1'b0);
            chk("sb_nonempty", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rx_data", RxData, e.data);
                chk("frame_err", RxFrameErr, e.ferr);
                chk("busy_with_done", RxBusy, 1'b0);
            end
        end
        done_prev = RxDone;
    end

    task automatic send_bit(input logic v);
        RxD = v;
        repeat (BIT_CLK) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic expect_done);
        if (expect_done) exp_q.push_back('{data: d, ferr: ~stop_v});
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_v);
    endtask

    task automatic idle_bits(input int n);
        RxD = 1'b1;
        repeat (n * BIT_CLK) @(negedge Clk);
    endtask

    int n0;

    initial begin
        #1;
        chk("rst_data", RxData, 8'h00);
        chk("rst_done", RxDone, 1'b0);
        chk("rst_ferr", RxFrameErr, 1'b0);
        chk("rst_busy", RxBusy, 1'b0);
        repeat (4) @(negedge Clk);
        Rst_n = 1'b1;
        RxEn  = 1'b1;
        idle_bits(2);

        // Good frame, busy observed mid-frame
        n0 = done_cnt;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                repeat (3 * BIT_CLK) @(negedge Clk);
                chk("busy_mid", RxBusy, 1'b1);
            end
        join
        idle_bits(1);
        chk("a5_count", done_cnt - n0, 1);
        chk("a5_busy_after", RxBusy, 1'b0);

        // Bad stop bit; RxEn dropped during it so the low tail is not taken as a start
        fork
            send_frame(8'h3C, 1'b0, 1'b1);
            begin
                repeat (9 * BIT_CLK) @(negedge Clk);
                RxEn = 1'b0;
            end
        join
        idle_bits(1);
        chk("3c_ferr_held", RxFrameErr, 1'b1);
        RxEn = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b1);
        idle_bits(1);
        chk("5a_ferr_cleared", RxFrameErr, 1'b0);

        // Short low glitch: 3 ticks
        n0 = done_cnt;
        RxD = 1'b0;
        repeat (12) @(negedge Clk);
        idle_bits(3);
        chk("glitch_no_done", done_cnt - n0, 0);
        chk("glitch_busy", RxBusy, 1'b0);
        chk("glitch_data", RxData, 8'h5A);

        // Back-to-back frames without gap
        n0 = done_cnt;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle_bits(1);
        chk("b2b_count", done_cnt - n0, 2);
        chk("b2b_spacing", last_done_cyc - prev_done_cyc, 10 * BIT_CLK);

        // Reset during data bit 4
        n0 = done_cnt;
        fork
            send_frame(8'h96, 1'b1, 1'b0);
            begin
                repeat (5 * BIT_CLK + 32) @(negedge Clk);
                Rst_n = 1'b0;
                RxEn  = 1'b0;
                #1;
                chk("mrst_data", RxData, 8'h00);
                chk("mrst_busy", RxBusy, 1'b0);
                chk("mrst_ferr", RxFrameErr, 1'b0);
                chk("mrst_done", RxDone, 1'b0);
                @(negedge Clk);
                Rst_n = 1'b1;
            end
        join
        idle_bits(2);
        chk("mrst_no_done", done_cnt - n0, 0);
        RxEn = 1'b1;
        send_frame(8'h69, 1'b1, 1'b1);
        idle_bits(1);

        // Disabled receiver ignores a whole frame
        n0 = done_cnt;
        RxEn = 1'b0;
        send_frame(8'h81, 1'b1, 1'b0);
        idle_bits(1);
        chk("dis_no_done", done_cnt - n0, 0);
        chk("dis_data_held", RxData, 8'h69);

        // Enable raised part-way into the start bit of 0x42
        n0 = done_cnt;
        fork
            send_frame(8'h42, 1'b1, 1'b1);
            begin
                repeat (8) @(negedge Clk);
                RxEn = 1'b1;
            end
        join
        idle_bits(1);
        chk("en_mid_count", done_cnt - n0, 1);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

UART serial receiver and the consumer of the baud-rate generator's `Tick`. It runs on a 16x-oversampling `Tick` strobe and synchronizes the asynchronous `RxD` line. It validates the start bit at mid-bit, shifts in data LSB-first, checks the stop bit, and presents each received word with a one-cycle `RxDone` pulse and a frame-error flag. It sits between the `RxD` pad and the receive-side host/FIFO logic.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `OVERSAMPLE`, 16: `Tick` pulses per bit period; must be even and at least 4.

Ports:
- `Clk`  in  1: system clock; all logic on the rising edge.
- `Rst_n`  in  1: reset, asynchronous assert, active-low.
- `Tick`  in  1: one-`Clk` oversample strobe from the baud-rate generator. Its rate is `OVERSAMPLE` × baud.
- `RxEn`  in  1: receive enable; sampled only in IDLE.
- `RxD`  in  1: serial input, asynchronous, idle-high.
- `RxData`  out  `DATA_BITS`: last received word; held until the next `RxDone`.
- `RxDone`  out  1: one-`Clk` pulse when a frame completes.
- `RxFrameErr`  out  1: stop-bit status of the last frame; valid with `RxDone` and held afterwards.
- `RxBusy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- `RxD` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- Internal state:
  - tick counter `cnt`, width clog2(`OVERSAMPLE`);
  - bit index, width clog2(`DATA_BITS`+1);
  - shift register, `DATA_BITS` wide.
- FSM states are IDLE, START, DATA and STOP. All state actions happen only on cycles where `Tick`=1; with `Tick`=0, state and counters hold.
- IDLE:
  - if `RxEn`=1 and `rxs`=0 on a tick: go to START with `cnt`=0;
  - otherwise stay in IDLE.
- START, on each tick:
  - if `cnt`=`OVERSAMPLE`/2−1 and `rxs`=0: go to DATA, `cnt`=0, bit index=0;
  - if `cnt`=`OVERSAMPLE`/2−1 and `rxs`=1: false start, return to IDLE with no output change;
  - otherwise `cnt`++.
- DATA, on each tick:
  - if `cnt`=`OVERSAMPLE`−1: shift `rxs` in at the MSB (right shift, so LSB-first on the line), bit index++, `cnt`=0;
  - after the `DATA_BITS`-th sample: go to STOP;
  - otherwise `cnt`++.
- STOP, on each tick:
  - if `cnt`=`OVERSAMPLE`−1: load `RxData` from the shift register, `RxFrameErr`=~`rxs`, pulse `RxDone`, go to IDLE;
  - otherwise `cnt`++.
- A frame error still delivers the data word. There is no resynchronisation hunt: IDLE simply waits for the next low sample.
- `RxEn` deasserted mid-frame has no effect; the current frame completes.
- There is no parity and there is one stop bit.

## Timing
- Reset values: `RxData`=0, `RxDone`=0, `RxFrameErr`=0, `RxBusy`=0, FSM=IDLE, counters=0, shift register=0.
- `RxD` → `rxs` latency is 2 `Clk`.
- Start is detected on the first tick that sees `rxs`=0. Start validation occurs `OVERSAMPLE`/2 ticks later.
- Each data bit is sampled `OVERSAMPLE` ticks after the previous sample, i.e. near mid-bit with ±1 tick of jitter.
- `RxDone`, `RxData` and `RxFrameErr` are registered. They update in the `Clk` cycle after the tick that samples the stop bit. `RxDone` is high for exactly one `Clk`.
- `RxBusy` rises the cycle after the start-detect tick and falls together with `RxDone`.
- Back-to-back frames: a start bit immediately after a stop bit is detected on the first tick after returning to IDLE. No gap cycles are required.
- Asynchronous reset mid-frame: all state returns to reset values immediately and no `RxDone` is produced. After release, the line is re-hunted from IDLE; a frame in progress is treated as noise unless `rxs` is low on a tick.
- Tick spacing of 1 `Clk` (a continuous `Tick`) is legal and must work.

## Test plan
- Frame 0xA5 with a good stop bit, `Tick` every 4 `Clk`, bit period 64 `Clk` → exactly one `RxDone`, `RxData`=0xA5, `RxFrameErr`=0, `RxBusy` low afterwards.
- Frame 0x3C with the stop bit driven 0 → `RxDone` pulse, `RxData`=0x3C, `RxFrameErr`=1. A following good frame 0x5A clears `RxFrameErr` to 0.
- `RxD` low glitch of 3 ticks (shorter than `OVERSAMPLE`/2) → no `RxDone`, `RxBusy` returns to 0, `RxData` unchanged.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `RxDone` pulses exactly 10 bit-periods apart, with data 0x00 then 0xFF.
- `Rst_n` pulsed low during data bit 4 of 0x96 → outputs return to 0 immediately, no `RxDone`. The next full frame 0x69 is received correctly.
- `RxEn`=0 during a complete 0x81 frame → no `RxDone`. `RxEn` raised mid-frame of 0x42 with `DATA_BITS`=8 → that frame still completes and `RxDone` pulses.
